axi_rdata_dispatch: RTL and testbench
=====================================

Name: axi_rdata_dispatch

Overview:
- Sits directly downstream of the AXI read-ID FIFO on the read-data path.
- Pops the one-hot decompressor select for each outstanding read burst from that FIFO.
- Steers every R-channel beat of the burst to the selected decompressor through a 2-entry per-lane output buffer.
- Holds the FIFO entry until the burst's RLAST beat is accepted, then moves to the next burst with no bubble.

Parameters:
NUM_DECOMPRESSOR, 2, number of decompressor lanes; width of the one-hot select.
DATA_WIDTH, 512, AXI read data width in bits.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
fifo_select  in  NUM_DECOMPRESSOR  one-hot lane select at the ID FIFO head; combinational from the FIFO.
fifo_empty  in  1  ID FIFO empty.
fifo_rd_en  out  1  ID FIFO pop strobe, one cycle per burst.
m_axi_rdata  in  DATA_WIDTH  read data.
m_axi_rresp  in  2  read response.
m_axi_rlast  in  1  last beat of the burst.
m_axi_rvalid  in  1  beat valid.
m_axi_rready  out  1  beat accept.
dec_data  out  NUM_DECOMPRESSOR*DATA_WIDTH  per-lane data; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
dec_last  out  NUM_DECOMPRESSOR  per-lane last-beat flag.
dec_valid  out  NUM_DECOMPRESSOR  per-lane valid.
dec_ready  in  NUM_DECOMPRESSOR  per-lane ready.
err_resp  out  1  sticky: a beat was received with non-OKAY rresp.
err_select  out  1  sticky: a popped select was not one-hot.

Behaviour:
- Reset (synchronous, active-high) applies at any time, including mid-burst:
  - state=IDLE; sel_r=0; all lane buffers emptied.
  - Outputs: fifo_rd_en=0, m_axi_rready=0, dec_valid=0, dec_last=0, dec_data=0, err_resp=0, err_select=0.
  - In-flight beats are discarded; the ID FIFO is reset by the same reset.
- States: IDLE, BURST, DRAIN.
- IDLE:
  - m_axi_rready=0.
  - If fifo_empty=0: fifo_rd_en=1 for that cycle and sel_r<=fifo_select.
  - Next state is BURST if fifo_select is one-hot; otherwise DRAIN and err_select<=1.
  - rvalid arriving while the FIFO is empty is stalled, not flagged.
- BURST:
  - m_axi_rready = (count of lane sel_r < 2). Depends only on registered state; no combinational path from rvalid.
  - An accepted beat (rvalid & rready) is written into lane sel_r's buffer as {rdata, rlast}.
  - If rresp != 2'b00: err_resp<=1 and the beat is still forwarded.
  - On an accepted beat with rlast=1:
    - If fifo_empty=0: pop the FIFO in the same cycle and load sel_r from fifo_select. Stay in BURST (or go to DRAIN if that select is not one-hot).
    - Otherwise go to IDLE.
  - fifo_rd_en is never asserted twice for one burst.
- DRAIN:
  - m_axi_rready=1; beats are discarded and err_resp is still updated.
  - The rlast beat exits using the same rules as BURST.
- Lane buffer (one per lane): 2-entry FIFO, count 0..2.
  - dec_valid[i] = (count!=0); dec_data/dec_last come from the head entry.
  - Pop on dec_valid & dec_ready.
  - Push and pop in the same cycle leave count unchanged.
  - dec_data holds its value while dec_valid=1 and dec_ready=0.
- Latency: a beat accepted in cycle t is visible on dec_* in cycle t+1.
- Throughput: 1 beat/cycle sustained when dec_ready is held high.
- Ordering: beats to a lane stay in order, and bursts are dispatched strictly in FIFO order.
- Lanes drain independently; back-pressure on one lane never blocks another lane's already-buffered data.
- err_resp and err_select clear only on reset.

Test Plan:
- Single burst: reset, push select 2'b01, send 4 beats D0..D3 with rlast on D3, dec_ready=11 → fifo_rd_en pulses once, lane0 emits D0..D3 at t+1 each with dec_last on D3, lane1 stays idle, state returns to IDLE.
- Back-to-back: FIFO holds 2'b01 then 2'b10, two 2-beat bursts sent with rvalid held high → no gap cycle; the pop for the second burst coincides with acceptance of the first rlast; lane1 receives beats 2-3.
- Back-pressure: lane0 dec_ready=0 during a 5-beat burst → rready drops after 2 beats are accepted; releasing dec_ready delivers all 5 beats in order with no loss or duplication.
- Error response: beat 1 of 3 has rresp=2'b10 → err_resp=1 from the next cycle, all 3 beats still delivered; err_resp stays set until rst.
- Bad select: FIFO head 2'b11 followed by a 3-beat burst → err_select=1, rready=1 for all 3 beats, no dec_valid on either lane; the next valid burst is routed normally.
- Reset mid-burst: assert rst after 2 of 4 beats → next cycle shows dec_valid=0, rready=0, fifo_rd_en=0, errors cleared; a fresh burst after reset is dispatched correctly.

Source files
------------

// File: rtl/axi_rdata_dispatch_if.sv
// ----------------------------------------------------------------------------
// axi_rdata_dispatch_if
//   Bundles every non-clock signal of the read-data dispatcher: the ID FIFO
//   head (select/empty/pop), the AXI R channel, the per-lane decompressor
//   streams and the sticky error flags.
//
//   Modports:
//     master : the dispatcher. Drives fifo_rd_en, m_axi_rready, dec_* outputs
//              and the error flags. Samples the FIFO head, R channel and
//              dec_ready.
//     slave  : the surrounding logic (ID FIFO, AXI port, decompressors).
//
//   Lane i of dec_data occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
// ----------------------------------------------------------------------------
interface axi_rdata_dispatch_if #(
    parameter int NUM_DECOMPRESSOR = 2,
    parameter int DATA_WIDTH       = 512
);
    // ID FIFO head
    logic [NUM_DECOMPRESSOR-1:0]            fifo_select;
    logic                                   fifo_empty;
    logic                                   fifo_rd_en;
    // AXI read-data channel
    logic [DATA_WIDTH-1:0]                  m_axi_rdata;
    logic [1:0]                             m_axi_rresp;
    logic                                   m_axi_rlast;
    logic                                   m_axi_rvalid;
    logic                                   m_axi_rready;
    // Decompressor lanes
    logic [NUM_DECOMPRESSOR*DATA_WIDTH-1:0] dec_data;
    logic [NUM_DECOMPRESSOR-1:0]            dec_last;
    logic [NUM_DECOMPRESSOR-1:0]            dec_valid;
    logic [NUM_DECOMPRESSOR-1:0]            dec_ready;
    // Sticky error flags
    logic                                   err_resp;
    logic                                   err_select;

    modport master (
        input  fifo_select, fifo_empty,
        output fifo_rd_en,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output dec_data, dec_last, dec_valid,
        input  dec_ready,
        output err_resp, err_select
    );

    modport slave (
        output fifo_select, fifo_empty,
        input  fifo_rd_en,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  dec_data, dec_last, dec_valid,
        output dec_ready,
        input  err_resp, err_select
    );
endinterface

// File: rtl/axi_rdata_dispatch.sv
// ----------------------------------------------------------------------------
// axi_rdata_dispatch
//   Read-data dispatcher sitting behind the AXI read-ID FIFO. For every
//   outstanding burst it pops the one-hot decompressor select from the FIFO
//   head, then steers each R beat of that burst into a 2-entry buffer of the
//   selected lane. The FIFO entry is held until the RLAST beat is accepted;
//   the next select is popped in that same cycle so consecutive bursts run
//   without a bubble. A select that is not one-hot sends the burst to a
//   drain state that swallows its beats and raises err_select.
//
//   Ports:
//     clk  : clock, rising edge.
//     rst  : synchronous, active-high reset (clears FSM, lane buffers, flags).
//     bus  : axi_rdata_dispatch_if.master -- FIFO head, R channel,
//            decompressor lanes and error flags.
// ----------------------------------------------------------------------------
module axi_rdata_dispatch #(
    parameter int NUM_DECOMPRESSOR = 2,
    parameter int DATA_WIDTH       = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_rdata_dispatch_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                      r_state;
    logic [NUM_DECOMPRESSOR-1:0] r_sel;
    logic                        r_err_resp;
    logic                        r_err_select;

    logic [NUM_DECOMPRESSOR-1:0] w_lane_full;
    logic                        w_rready;
    logic                        w_accept;
    logic                        w_burst_end;
    logic                        w_fifo_pop;
    logic                        w_sel_onehot;

    assign w_sel_onehot = $onehot(bus.fifo_select);

    // rready is a function of registered state only, so there is no
    // combinational path from rvalid back to rready. While reset is held the
    // port refuses beats; they would be thrown away anyway.
    always_comb begin
        w_rready = 1'b0;
        unique case (r_state)
            ST_BURST: w_rready = |(r_sel & ~w_lane_full);
            ST_DRAIN: w_rready = 1'b1;
            default:  w_rready = 1'b0;
        endcase
        if (rst) begin
            w_rready = 1'b0;
        end
    end

    assign w_accept    = bus.m_axi_rvalid & w_rready;
    assign w_burst_end = w_accept & bus.m_axi_rlast;

    // One pop per burst: either the first burst out of IDLE, or the next
    // burst popped in the very cycle the current RLAST is accepted.
    assign w_fifo_pop = ~rst & ~bus.fifo_empty &
                        ((r_state == ST_IDLE) | w_burst_end);

    assign bus.fifo_rd_en   = w_fifo_pop;
    assign bus.m_axi_rready = w_rready;
    assign bus.err_resp     = r_err_resp;
    assign bus.err_select   = r_err_select;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_err_resp   <= 1'b0;
            r_err_select <= 1'b0;
        end else begin
            // Error responses are flagged in both BURST and DRAIN.
            if (w_accept && (bus.m_axi_rresp != 2'b00)) begin
                r_err_resp <= 1'b1;
            end

            if (w_fifo_pop) begin
                r_sel <= bus.fifo_select;
                if (w_sel_onehot) begin
                    r_state <= ST_BURST;
                end else begin
                    r_state      <= ST_DRAIN;
                    r_err_select <= 1'b1;
                end
            end else if (w_burst_end) begin
                r_state <= ST_IDLE;
                r_sel   <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-lane 2-entry output buffers. Each lane drains on its own dec_ready,
    // so a stalled lane never holds up data already buffered in another.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DECOMPRESSOR; gi++) begin : g_lane
            logic [DATA_WIDTH:0] r_mem [2];   // {data, last}
            logic                r_wr_ptr;
            logic                r_rd_ptr;
            logic [1:0]          r_count;
            logic                w_push;
            logic                w_pop;
            logic                w_valid;
            logic [DATA_WIDTH:0] w_head;

            // Pushes only happen in BURST, where r_sel is known one-hot.
            assign w_push  = w_accept & (r_state == ST_BURST) & r_sel[gi];
            assign w_valid = (r_count != 2'd0);
            assign w_pop   = w_valid & bus.dec_ready[gi];
            assign w_head  = r_mem[r_rd_ptr];

            assign w_lane_full[gi] = (r_count == 2'd2);

            // Outputs are forced to zero when the lane is empty so stale
            // entries never leak out (and reset reads back as all-zero).
            assign bus.dec_valid[gi]                          = w_valid;
            assign bus.dec_last[gi]                           = w_valid & w_head[0];
            assign bus.dec_data[gi*DATA_WIDTH +: DATA_WIDTH]  =
                w_valid ? w_head[DATA_WIDTH:1] : '0;

            // Storage carries no reset; the count gates every read of it.
            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= {bus.m_axi_rdata, bus.m_axi_rlast};
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr <= 1'b0;
                    r_rd_ptr <= 1'b0;
                    r_count  <= 2'd0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= ~r_wr_ptr;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= ~r_rd_ptr;
                    end
                    unique case ({w_push, w_pop})
                        2'b10:   r_count <= r_count + 2'd1;
                        2'b01:   r_count <= r_count - 2'd1;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_axi_rdata_dispatch.sv
// ----------------------------------------------------------------------------
// tb_axi_rdata_dispatch
//   Directed bench for axi_rdata_dispatch. The bench models the ID FIFO and
//   the AXI R source; every beat routed to a lane is pushed to that lane's
//   expected queue when it is queued for transmission, and popped/compared
//   when the lane hands it to the decompressor.
// ----------------------------------------------------------------------------
module tb_axi_rdata_dispatch;

    localparam int N  = 2;
    localparam int DW = 512;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    axi_rdata_dispatch_if #(.NUM_DECOMPRESSOR(N), .DATA_WIDTH(DW)) bus ();

    axi_rdata_dispatch #(.NUM_DECOMPRESSOR(N), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ID FIFO model
    logic [N-1:0] id_mem [16];
    int           wr_idx = 0;
    int           rd_idx = 0;

    // R source and per-lane scoreboards
    beat_t         tx_q [$];
    logic [DW:0]   exp0 [$];
    logic [DW:0]   exp1 [$];
    logic [DW-1:0] burst_data [8];

    int   pop_count = 0;
    int   acc_count = 0;
    logic last_accept, last_rlast, last_pop;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bus();
        beat_t h;
        bus.fifo_empty  = (rd_idx == wr_idx);
        bus.fifo_select = (rd_idx == wr_idx) ? '0 : id_mem[rd_idx];
        if (tx_q.size() != 0) begin
            h = tx_q[0];
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = h.data;
            bus.m_axi_rresp  = h.resp;
            bus.m_axi_rlast  = h.last;
        end else begin
            bus.m_axi_rvalid = 1'b0;
            bus.m_axi_rdata  = '0;
            bus.m_axi_rresp  = 2'b00;
            bus.m_axi_rlast  = 1'b0;
        end
    endtask

    task automatic push_id(input logic [N-1:0] sel);
        id_mem[wr_idx] = sel;
        wr_idx++;
        drive_bus();
    endtask

    // Queue a burst; if route=1 each beat is also expected on 'lane'.
    task automatic queue_burst(input int lane, input int nbeats, input bit route, input int err_beat);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            for (int w = 0; w < DW / 32; w++) begin
                b.data[w*32 +: 32] = $urandom;
            end
            b.last = (i == nbeats - 1);
            b.resp = (i == err_beat) ? 2'b10 : 2'b00;
            burst_data[i] = b.data;
            tx_q.push_back(b);
            if (route) begin
                if (lane == 0) exp0.push_back({b.data, b.last});
                else           exp1.push_back({b.data, b.last});
            end
        end
        drive_bus();
    endtask

    task automatic mon_lane(input int l);
        logic [DW:0] head;
        int          sz;
        sz = (l == 0) ? exp0.size() : exp1.size();
        if (bus.dec_valid[l] !== 1'b1) return;
        n_cmp++;
        assert (sz > 0) else begin
            n_bad++;
            $error("FAIL lane%0d_spurious: got dec_valid=1 expected no pending beat", l);
        end
        if (sz == 0) return;
        head = (l == 0) ? exp0[0] : exp1[0];
        check($sformatf("lane%0d_data", l), bus.dec_data[l*DW +: DW], head[DW:1]);
        check($sformatf("lane%0d_last", l), DW'(bus.dec_last[l]), DW'(head[0]));
        if (bus.dec_ready[l]) begin
            if (l == 0) exp0.delete(0);
            else        exp1.delete(0);
        end
    endtask

    // One clock: sample at the falling edge, update the models after the
    // rising edge, then re-drive the inputs.
    task automatic tick();
        @(negedge clk);
        for (int l = 0; l < N; l++) mon_lane(l);
        last_accept = bus.m_axi_rvalid && bus.m_axi_rready;
        last_rlast  = last_accept && bus.m_axi_rlast;
        last_pop    = bus.fifo_rd_en;
        if (last_pop) check("pop_while_empty", DW'(bus.fifo_empty), DW'(0));
        @(posedge clk);
        #1;
        if (last_accept) begin
            tx_q.delete(0);
            acc_count++;
        end
        if (last_pop) begin
            rd_idx++;
            pop_count++;
        end
        drive_bus();
    endtask

    task automatic run_done(input string tag);
        for (int c = 0; c < 300; c++) begin
            if (tx_q.size() == 0 && exp0.size() == 0 && exp1.size() == 0) break;
            tick();
        end
        check({tag, "_leftover"}, DW'(tx_q.size() + exp0.size() + exp1.size()), DW'(0));
    endtask

    int p0, a0, first_acc, last_acc, cyc;

    initial begin
        rst           = 1'b1;
        bus.dec_ready = 2'b11;
        drive_bus();
        repeat (3) tick();

        // ---------------- reset state ----------------
        check("rst_rd_en",   DW'(bus.fifo_rd_en),   DW'(0));
        check("rst_rready",  DW'(bus.m_axi_rready), DW'(0));
        check("rst_valid",   DW'(bus.dec_valid),    DW'(0));
        check("rst_last",    DW'(bus.dec_last),     DW'(0));
        check("rst_data0",   bus.dec_data[0 +: DW], '0);
        check("rst_data1",   bus.dec_data[DW +: DW], '0);
        check("rst_err_resp",   DW'(bus.err_resp),   DW'(0));
        check("rst_err_select", DW'(bus.err_select), DW'(0));
        rst = 1'b0;
        tick();

        // ---------------- single burst to lane 0 ----------------
        p0 = pop_count; a0 = acc_count;
        push_id(2'b01);
        queue_burst(0, 4, 1'b1, -1);
        for (int c = 0; c < 20 && acc_count == a0; c++) tick();
        check("t1_lat_valid", DW'(bus.dec_valid), DW'(2'b01));
        check("t1_lat_data",  bus.dec_data[0 +: DW], burst_data[0]);
        run_done("t1");
        check("t1_pops", DW'(pop_count - p0), DW'(1));
        repeat (2) tick();
        check("t1_idle_rready", DW'(bus.m_axi_rready), DW'(0));
        check("t1_idle_rd_en",  DW'(bus.fifo_rd_en),   DW'(0));

        // ---------------- back-to-back bursts ----------------
        p0 = pop_count; a0 = acc_count;
        first_acc = -1; last_acc = -1;
        push_id(2'b01);
        push_id(2'b10);
        queue_burst(0, 2, 1'b1, -1);
        queue_burst(1, 2, 1'b1, -1);
        for (cyc = 0; cyc < 40 && acc_count < a0 + 4; cyc++) begin
            tick();
            if (last_accept) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (last_pop && pop_count == p0 + 2)
                check("t2_pop_on_rlast", DW'({last_accept, last_rlast}), DW'(2'b11));
        end
        check("t2_no_gap", DW'(last_acc - first_acc + 1), DW'(4));
        run_done("t2");
        check("t2_pops", DW'(pop_count - p0), DW'(2));

        // ---------------- back-pressure on lane 0 ----------------
        bus.dec_ready = 2'b10;
        a0 = acc_count;
        push_id(2'b01);
        queue_burst(0, 5, 1'b1, -1);
        repeat (6) tick();
        check("t3_acc_stalled", DW'(acc_count - a0), DW'(2));
        check("t3_rready_low",  DW'(bus.m_axi_rready), DW'(0));
        bus.dec_ready = 2'b11;
        run_done("t3");
        check("t3_acc_total", DW'(acc_count - a0), DW'(5));

        // ---------------- error response ----------------
        check("t4_err_pre", DW'(bus.err_resp), DW'(0));
        a0 = acc_count;
        push_id(2'b10);
        queue_burst(1, 3, 1'b1, 1);
        for (int c = 0; c < 20 && acc_count == a0; c++) tick();
        check("t4_err_beat0", DW'(bus.err_resp), DW'(0));
        tick();
        check("t4_err_beat1", DW'(bus.err_resp), DW'(1));
        run_done("t4");
        repeat (3) tick();
        check("t4_err_sticky", DW'(bus.err_resp), DW'(1));

        // ---------------- bad select ----------------
        check("t5_errsel_pre", DW'(bus.err_select), DW'(0));
        p0 = pop_count; a0 = acc_count;
        push_id(2'b11);
        push_id(2'b01);
        queue_burst(0, 3, 1'b0, -1);
        queue_burst(0, 2, 1'b1, -1);
        for (int c = 0; c < 20 && pop_count == p0; c++) tick();
        check("t5_errsel_set", DW'(bus.err_select), DW'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t5_drain_acc%0d", i), DW'(last_accept), DW'(1));
            check($sformatf("t5_drain_quiet%0d", i), DW'(bus.dec_valid), DW'(0));
        end
        check("t5_next_pop", DW'(pop_count - p0), DW'(2));
        run_done("t5");
        check("t5_errsel_sticky", DW'(bus.err_select), DW'(1));

        // ---------------- reset mid-burst ----------------
        a0 = acc_count;
        push_id(2'b01);
        queue_burst(0, 4, 1'b1, -1);
        for (int c = 0; c < 20 && acc_count < a0 + 2; c++) tick();
        rst = 1'b1;
        tick();
        check("t6_valid",   DW'(bus.dec_valid),    DW'(0));
        check("t6_rready",  DW'(bus.m_axi_rready), DW'(0));
        check("t6_rd_en",   DW'(bus.fifo_rd_en),   DW'(0));
        check("t6_err_resp",   DW'(bus.err_resp),   DW'(0));
        check("t6_err_select", DW'(bus.err_select), DW'(0));
        tx_q.delete();
        exp0.delete();
        exp1.delete();
        rd_idx = wr_idx;
        drive_bus();
        rst = 1'b0;
        tick();
        p0 = pop_count;
        push_id(2'b10);
        queue_burst(1, 3, 1'b1, -1);
        run_done("t6");
        check("t6_pops", DW'(pop_count - p0), DW'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
